// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants: RV32 opcode values, the canonical NOP and the default boot PC.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // The control decoder only looks at the low seven bits of the word.
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is ignored when full and pop when empty; flush wins over both.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign pop_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage is not reset: the head is only meaningful while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: owns the PC, requests words from imem, buffers in-order responses for decode.
// Latency: response-to-if_valid is 1 cycle (no bypass); a redirect retargets the very next request.
// Backpressure: requests are credit-limited to (inflight + buffered) < FIFO_DEPTH; decode stalls via if_ready.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   drop_q;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW:0]     occ;
  logic            req_fire;
  logic            resp_fire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;
  entry_t          push_entry;
  entry_t          head;

  assign target    = redirect_pc & ~XLEN'(3);
  assign occ       = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign resp_fire = imem_resp_valid;

  // rst_n gates the request so nothing is offered while held in reset; the first
  // request is therefore visible in the very first cycle after release.
  assign imem_req_valid = rst_n && !redirect_valid && (occ < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale responses (drop_q > 0) and any response racing a redirect are discarded.
  assign push       = resp_fire && (drop_q == '0) && !redirect_valid;
  assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};

  assign if_valid  = !fifo_empty && !redirect_valid;
  assign pop       = if_valid && if_ready;
  assign if_pc     = fifo_empty ? '0 : head.pc;
  assign if_instr  = fifo_empty ? '0 : head.instr;
  assign if_opcode = opcode_of(if_instr);

  fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .pop_dat  (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // PC, response-PC and credit bookkeeping; a redirect marks every outstanding
  // response stale, including one landing in the redirect cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else if (redirect_valid) begin
      pc_q       <= target;
      resp_pc_q  <= target;
      inflight_q <= inflight_q - CW'(resp_fire);
      drop_q     <= inflight_q - CW'(resp_fire);
    end else begin
      if (req_fire) pc_q <= pc_q + XLEN'(4);
      inflight_q <= inflight_q + CW'(req_fire) - CW'(resp_fire);
      if (resp_fire) begin
        if (drop_q != '0) drop_q <= drop_q - CW'(1);
        else              resp_pc_q <= resp_pc_q + XLEN'(4);
      end
    end
  end

  a_credit : assert property (@(posedge clk) disable iff (!rst_n) occ <= DEPTH_W);
  a_drop   : assert property (@(posedge clk) disable iff (!rst_n) drop_q <= inflight_q);
  a_nofull : assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: scripted stimulus, queue-based scoreboard, behavioural imem.
// Latency: memory answers one cycle after each accepted request unless stalled.
// Backpressure: if_ready and imem_req_ready are driven by the script.
module tb_cpu_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;

  int checks = 0;
  int errors = 0;
  int n_fire = 0;
  int n_deliv = 0;
  bit nop_mode = 1'b1;
  bit mem_stall = 1'b0;
  logic [31:0] model_pc = '0;
  logic [63:0] exp_q [$];
  logic [31:0] pend_q [$];

  always #5 clk = ~clk;

  cpu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_opcode       (if_opcode)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] opc;
    if (nop_mode) return NOP;
    case (a[3:2])
      2'd0:    opc = OPC_LOAD;
      2'd1:    opc = OPC_STORE;
      2'd2:    opc = OPC_OP;
      default: opc = OPC_BRANCH;
    endcase
    return {a[26:2], opc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold imem_req_ready until n requests are accepted; returns at posedge+1 after the last one.
  task automatic issue_n(input int n);
    int got;
    int budget;
    got = 0;
    budget = 0;
    imem_req_ready = 1'b1;
    while (got < n && budget < 60) begin
      @(negedge clk);
      if (imem_req_valid) got++;
      @(posedge clk);
      #1;
      budget++;
    end
    imem_req_ready = 1'b0;
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL issue_timeout accepted=%0d required=%0d", got, n);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // Memory: capture accepted requests at negedge, answer one per cycle after the next posedge.
  always begin
    @(negedge clk);
    if (rst_n && imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
    @(posedge clk);
    #2;
    if (!rst_n) begin
      pend_q.delete();
      imem_resp_valid = 1'b0;
    end else if (!mem_stall && pend_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
  end

  // Monitor: request addresses follow a sequential-PC model; deliveries pop the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      model_pc = 32'h0;
    end else begin
      if (redirect_valid) model_pc = redirect_pc & ~32'd3;
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, model_pc);
        model_pc = model_pc + 32'd4;
        n_fire++;
      end
      if (if_valid && if_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver_unexpected pc=%h instr=%h required=none", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", if_pc, e[63:32]);
          check("deliver_instr", if_instr, e[31:0]);
          check("deliver_opcode", 32'(if_opcode), 32'(e[6:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    imem_req_ready = 1'b1;
    cyc(2);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);

    // Test 1: first request right after release, if_valid two cycles later
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_c0_if_valid", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_c1_if_valid", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_c2_if_valid", 32'(if_valid), 32'd1);
    check("t1_c2_if_pc", if_pc, 32'd0);
    check("t1_c2_opcode", 32'(if_opcode), 32'h13);

    // Test 2: decode stalled, credits cap outstanding work at two
    for (int i = 0; i < 8; i++) begin
      check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("t2_fire_count", 32'(n_fire), 32'd2);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    push_exp(32'h0);
    push_exp(32'h4);
    if_ready = 1'b1;
    cyc(4);
    check("t2_deliv_count", 32'(n_deliv), 32'd2);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    nop_mode = 1'b0;

    // Test 3: redirect with two requests in flight
    mem_stall = 1'b1;
    issue_n(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    check("t3_redir_if_valid", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    @(negedge clk);
    check("t3_drop", 32'(dut.drop_q), 32'd2);
    check("t3_new_addr", imem_req_addr, 32'h100);
    @(posedge clk); #1;
    push_exp(32'h100);
    issue_n(1);
    cyc(5);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Test 4: redirect coinciding with a response and if_ready=1
    if_ready = 1'b0;
    issue_n(1);
    cyc(2);
    mem_stall = 1'b1;
    issue_n(1);
    mem_stall      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    if_ready       = 1'b1;
    @(negedge clk);
    check("t4_resp_same_cycle", 32'(imem_resp_valid), 32'd1);
    check("t4_if_valid_masked", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_drop", 32'(dut.drop_q), 32'd0);
    check("t4_inflight", 32'(dut.inflight_q), 32'd0);
    check("t4_flushed", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    push_exp(32'h200);
    issue_n(1);
    cyc(4);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back redirects: second target wins, stale count stays consistent
    mem_stall = 1'b1;
    issue_n(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(posedge clk); #1;
    redirect_pc = 32'h400;
    mem_stall   = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_drop", 32'(dut.drop_q), 32'd1);
    check("b2b_inflight", 32'(dut.inflight_q), 32'd1);
    check("b2b_addr", imem_req_addr, 32'h400);
    @(posedge clk); #1;
    push_exp(32'h400);
    issue_n(1);
    cyc(4);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Test 5: PC wraps from the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    issue_n(2);
    cyc(5);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: asynchronous reset with the buffer full
    if_ready = 1'b0;
    issue_n(2);
    cyc(3);
    @(negedge clk);
    check("t6_full_if_valid", 32'(if_valid), 32'd1);
    check("t6_head_pc", if_pc, 32'h4);
    check("t6_head_instr", if_instr, mem_word(32'h4));
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_async_if_valid", 32'(if_valid), 32'd0);
    check("t6_async_if_pc", if_pc, 32'd0);
    check("t6_async_if_instr", if_instr, 32'd0);
    check("t6_async_opcode", 32'(if_opcode), 32'd0);
    check("t6_async_addr", imem_req_addr, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    check("t6_restart_addr", imem_req_addr, 32'd0);
    check("t6_inflight", 32'(dut.inflight_q), 32'd0);
    check("t6_drop", 32'(dut.drop_q), 32'd0);
    @(posedge clk); #1;
    push_exp(32'h0);
    if_ready = 1'b1;
    issue_n(1);
    cyc(4);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
